wishbone_lsu_master: RTL
========================

Name: wishbone_lsu_master

Overview:
- Wishbone classic-cycle initiator connecting the core's memory stage (load/store unit) to the system bus; the counterpart of the bus's SRAM/peripheral responders.
- Accepts one byte, half or word access at a time from the core, then drives CYC/STB/WE/SEL/ADDR/DATA and holds them until ACK.
- Returns read data aligned and sign- or zero-extended, or reports an error.

Parameters:
- DATA_WIDTH, 32, bus data width (only 32 supported).
- ADDR_WIDTH, 32, bus and core address width.
- TIMEOUT_CYCLES, 255, ACK wait limit in clocks; used only when WB_TIMEOUT_EN is defined; 1..255.

Ports:
- i_CLK  in  1  system clock, rising edge.
- i_RST  in  1  reset, asynchronous, active-low (0 = reset).
- i_REQ  in  1  core access request; sampled in IDLE only.
- i_WE  in  1  1 = store, 0 = load.
- i_SIZE  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- i_UNSIGNED  in  1  zero-extend loads when 1.
- i_ADDR  in  ADDR_WIDTH  byte address.
- i_WDATA  in  DATA_WIDTH  store data, LSB-justified.
- o_RDATA  out  DATA_WIDTH  extended load result; valid while o_DONE = 1.
- o_DONE  out  1  one-cycle completion pulse.
- o_ERR  out  1  qualifies o_DONE: misaligned access or timeout.
- o_BUSY  out  1  high in BUS state.
- o_ADDR  out  ADDR_WIDTH  Wishbone address; full byte address, responder shifts it.
- o_DATA  out  DATA_WIDTH  Wishbone write data.
- i_DATA  in  DATA_WIDTH  Wishbone read data.
- o_WE  out  1  Wishbone write enable.
- o_SEL  out  4  Wishbone byte select.
- o_STB  out  1  Wishbone strobe.
- o_CYC  out  1  Wishbone cycle.
- i_ACK  in  1  Wishbone acknowledge.
- i_TAGN  in  1  responder tag; ignored.
- o_TAGN  out  1  tied 0.

Behaviour:
- Reset (i_RST = 0, asynchronous): state = IDLE; o_CYC, o_STB, o_WE, o_DONE, o_ERR = 0; o_SEL = 0; o_ADDR, o_DATA, o_RDATA = 0.
  - Reset during BUS aborts the cycle immediately; no o_DONE is generated.
- FSM: IDLE and BUS. All outputs are registered.
- IDLE:
  - i_REQ = 1 and aligned → next edge: state = BUS, o_CYC = o_STB = 1; o_ADDR, o_WE, o_SEL, o_DATA and the size/sign/offset context are latched.
  - i_REQ = 1 and misaligned (half with addr[0] = 1; word with addr[1:0] != 0) → no bus cycle; next cycle o_DONE = o_ERR = 1 and state stays IDLE.
- BUS: CYC, STB and all bus fields are held stable until i_ACK = 1 is sampled. On that edge:
  - o_CYC = o_STB = 0, state = IDLE.
  - o_DONE = 1 for exactly one cycle; o_RDATA is updated for loads (stores leave o_RDATA unchanged).
- Minimum latency: request sampled → CYC high on the next cycle → ACK in that same cycle (combinational responder) → o_DONE the following cycle. Total 2 clocks, request to done.
- A new i_REQ is accepted in the same cycle o_DONE is high, giving back-to-back accesses. Any request while o_BUSY = 1 is ignored (core must hold).
- i_ACK while in IDLE is ignored.
- Lane steering, with off = addr[1:0]:
  - Byte: SEL = 4'b0001 << off; o_DATA = wdata[7:0] replicated 4×.
  - Half: SEL = 4'b0011 << off; o_DATA = wdata[15:0] replicated 2×.
  - Word: SEL = 4'b1111; o_DATA = wdata.
  - Loads drive the same SEL.
- Load extraction: s = i_DATA >> (8·off). Byte → s[7:0], half → s[15:0]. Sign-extend from bit 7 or 15 unless i_UNSIGNED = 1; word returned unchanged.

Optional Feature:
- Macro WB_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to BUS and increments each BUS cycle without ACK. When it reaches TIMEOUT_CYCLES, CYC and STB drop, state = IDLE, and o_DONE = o_ERR = 1 next cycle.
  - ACK in the same cycle the limit is hit wins: normal completion, o_ERR = 0.
- Undefined: no counter; the master waits for ACK indefinitely.

Decomposition:
- Package pygmy_wb_pkg:
  - wb_size_t enum {SZ_BYTE, SZ_HALF, SZ_WORD}.
  - wb_master_state_t enum {WBM_IDLE, WBM_BUS}.
  - Constant WB_SEL_WIDTH = 4.
- One natural combinational sub-module, wb_lane_align: SEL/write-data steering and read extract/extend. It is reused by a future fetch master.

Test Plan:
- Store word 0xDEADBEEF to 0x100, ACK on first BUS cycle → o_ADDR = 0x100, o_SEL = 4'hF, o_WE = 1; o_DONE exactly 2 clocks after i_REQ; o_ERR = 0.
- Store byte 0xA5 to 0x103 → o_SEL = 4'b1000, o_DATA = 0xA5A5A5A5. Then load byte signed from 0x103 with i_DATA = 0xA5000000 → o_RDATA = 0xFFFFFFA5; unsigned → 0x000000A5.
- Load half from 0x102 with i_DATA = 0x80010000, ACK delayed 3 cycles → CYC/STB/ADDR stable for 3 cycles, o_SEL = 4'b1100, o_RDATA = 0xFFFF8001.
- Word load at 0x101 → no CYC ever asserted; o_DONE = o_ERR = 1 next cycle.
- i_RST pulled low mid-BUS → CYC/STB = 0 immediately, no o_DONE. After release, a fresh request completes normally.
- WB_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and ACK never given → CYC drops after 4 BUS cycles, then o_DONE = o_ERR = 1. Second run with ACK on the 4th cycle → o_ERR = 0.

Source files
------------

// File: rtl/pygmy_wb_pkg.sv
// Shared Wishbone master types: access size, master FSM state, byte-select width,
// plus helpers for size decoding and alignment checking.
package pygmy_wb_pkg;

    localparam int WB_SEL_WIDTH = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } wb_size_t;

    typedef enum logic {
        WBM_IDLE = 1'b0,
        WBM_BUS  = 1'b1
    } wb_master_state_t;

    // Encoding 3 is folded onto word.
    function automatic wb_size_t wb_decode_size(input logic [1:0] sz);
        case (sz)
            2'd0:    return SZ_BYTE;
            2'd1:    return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic wb_misaligned(input wb_size_t sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: return off[0];
            SZ_WORD: return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wishbone_lsu_master_if.sv
// Wishbone classic bus bundle between the LSU master and a responder.
// Signal names keep the master's point of view (o_* driven by master, i_* by responder).
interface wishbone_lsu_master_if
    import pygmy_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   o_ADDR;
    logic [DATA_WIDTH-1:0]   o_DATA;
    logic [DATA_WIDTH-1:0]   i_DATA;
    logic                    o_WE;
    logic [WB_SEL_WIDTH-1:0] o_SEL;
    logic                    o_STB;
    logic                    o_CYC;
    logic                    i_ACK;
    logic                    i_TAGN;
    logic                    o_TAGN;

    modport master (
        output o_ADDR, o_DATA, o_WE, o_SEL, o_STB, o_CYC, o_TAGN,
        input  i_DATA, i_ACK, i_TAGN
    );

    modport slave (
        input  o_ADDR, o_DATA, o_WE, o_SEL, o_STB, o_CYC, o_TAGN,
        output i_DATA, i_ACK, i_TAGN
    );
endinterface

// File: rtl/wb_lane_align.sv
// Combinational byte-lane steering: store SEL/data replication and load extract/extend.
// Only a 32-bit data path is supported.
module wb_lane_align
    import pygmy_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wb_size_t                w_size_i,
    input  logic [1:0]              w_off_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [WB_SEL_WIDTH-1:0] sel_o,
    output logic [DATA_WIDTH-1:0]   bus_wdata_o,
    input  wb_size_t                r_size_i,
    input  logic [1:0]              r_off_i,
    input  logic                    r_unsigned_i,
    input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        sel_o       = '1;
        bus_wdata_o = wdata_i;
        case (w_size_i)
            SZ_BYTE: begin
                sel_o       = 4'b0001 << w_off_i;
                bus_wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                sel_o       = 4'b0011 << w_off_i;
                bus_wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Aligned words always have a zero offset, so the shifted value is the raw word.
    always_comb begin
        shifted = bus_rdata_i >> {r_off_i, 3'b000};
        case (r_size_i)
            SZ_BYTE: rdata_o = {{24{shifted[7]  & ~r_unsigned_i}}, shifted[7:0]};
            SZ_HALF: rdata_o = {{16{shifted[15] & ~r_unsigned_i}}, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end
endmodule

// File: rtl/wishbone_lsu_master.sv
// Wishbone classic-cycle initiator for the LSU: one byte/half/word access at a time.
// Optional ACK watchdog enabled by defining WB_TIMEOUT_EN.
module wishbone_lsu_master
    import pygmy_wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_REQ,
    input  logic                  i_WE,
    input  logic [1:0]            i_SIZE,
    input  logic                  i_UNSIGNED,
    input  logic [ADDR_WIDTH-1:0] i_ADDR,
    input  logic [DATA_WIDTH-1:0] i_WDATA,
    output logic [DATA_WIDTH-1:0] o_RDATA,
    output logic                  o_DONE,
    output logic                  o_ERR,
    output logic                  o_BUSY,
    wishbone_lsu_master_if.master wb
);
    wb_master_state_t        state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [WB_SEL_WIDTH-1:0] sel_q, sel_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    wb_size_t                size_q, size_d;
    logic [1:0]              off_q, off_d;
    logic                    uns_q, uns_d;

    wb_size_t                req_size;
    logic [WB_SEL_WIDTH-1:0] steer_sel;
    logic [DATA_WIDTH-1:0]   steer_data;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    tmo_hit;
    logic                    unused_tagn;

    assign req_size    = wb_decode_size(i_SIZE);
    assign unused_tagn = wb.i_TAGN;

    wb_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .w_size_i     (req_size),
        .w_off_i      (i_ADDR[1:0]),
        .wdata_i      (i_WDATA),
        .sel_o        (steer_sel),
        .bus_wdata_o  (steer_data),
        .r_size_i     (size_q),
        .r_off_i      (off_q),
        .r_unsigned_i (uns_q),
        .bus_rdata_i  (wb.i_DATA),
        .rdata_o      (load_data)
    );

`ifdef WB_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (state_q == WBM_BUS) && (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));

    // Held at zero while idle, so every BUS entry starts from a cleared count.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == WBM_IDLE)
            tmo_cnt_d = '0;
        else if (!wb.i_ACK && !tmo_hit)
            tmo_cnt_d = tmo_cnt_q + 8'd1;
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        size_d  = size_q;
        off_d   = off_q;
        uns_d   = uns_q;
        case (state_q)
            WBM_IDLE: begin
                if (i_REQ) begin
                    if (wb_misaligned(req_size, i_ADDR[1:0])) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = WBM_BUS;
                        cyc_d   = 1'b1;
                        we_d    = i_WE;
                        addr_d  = i_ADDR;
                        data_d  = steer_data;
                        sel_d   = steer_sel;
                        size_d  = req_size;
                        off_d   = i_ADDR[1:0];
                        uns_d   = i_UNSIGNED;
                    end
                end
            end
            WBM_BUS: begin
                // ACK takes priority over a watchdog expiry in the same cycle.
                if (wb.i_ACK) begin
                    state_d = WBM_IDLE;
                    cyc_d   = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) rdata_d = load_data;
                end else if (tmo_hit) begin
                    state_d = WBM_IDLE;
                    cyc_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: state_d = WBM_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q <= WBM_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            size_q  <= SZ_BYTE;
            off_q   <= '0;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
        end
    end

    // CYC and STB are the same registered bit in a classic single-beat cycle.
    assign wb.o_CYC  = cyc_q;
    assign wb.o_STB  = cyc_q;
    assign wb.o_WE   = we_q;
    assign wb.o_ADDR = addr_q;
    assign wb.o_DATA = data_q;
    assign wb.o_SEL  = sel_q;
    assign wb.o_TAGN = 1'b0;
    assign o_RDATA   = rdata_q;
    assign o_DONE    = done_q;
    assign o_ERR     = err_q;
    assign o_BUSY    = (state_q == WBM_BUS);
endmodule
